// File: rtl/ysyx_22050243_mem_pkg.sv
// Shared definitions for the LSU data-memory port: FSM states, access size
// encodings, the 64-bit memory word width, and the physical-memory routines.
// The MEM_pmem_* routines are a behavioural stand-in for the simulator's C-side
// memory, keeping the same call shape so the LSU simulates without a C harness.
package ysyx_22050243_mem_pkg;

  localparam int PMEM_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mem_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Byte-enable pattern for an access of this size starting at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Sparse physical memory, one 64-bit word per 8-byte aligned address, plus
  // a record of the traffic it has seen.
  bit [63:0]   pmem [bit [63:0]];
  int unsigned pmem_rd_cnt;
  int unsigned pmem_wr_cnt;
  bit [63:0]   pmem_last_waddr;
  bit [63:0]   pmem_last_wdata;
  bit [7:0]    pmem_last_wmask;

  function automatic void MEM_pmem_read(input logic [63:0] raddr,
                                        output logic [63:0] rdata,
                                        input logic ren);
    rdata = 64'h0;
    if (ren) begin
      if (pmem.exists(raddr)) rdata = pmem[raddr];
      pmem_rd_cnt = pmem_rd_cnt + 1;
    end
  endfunction

  function automatic void MEM_pmem_write(input logic [63:0] waddr,
                                         input logic [63:0] wdata,
                                         input logic [7:0] wmask,
                                         input logic wen);
    bit [63:0] word;
    if (wen) begin
      word = pmem.exists(waddr) ? pmem[waddr] : 64'h0;
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      pmem[waddr]     = word;
      pmem_wr_cnt     = pmem_wr_cnt + 1;
      pmem_last_waddr = waddr;
      pmem_last_wdata = wdata;
      pmem_last_wmask = wmask;
    end
  endfunction

  // Side-effect-free look at a memory word, for inspection outside the LSU.
  function automatic logic [63:0] pmem_peek(input logic [63:0] addr);
    return pmem.exists(addr) ? pmem[addr] : 64'h0;
  endfunction

endpackage

// File: rtl/ysyx_22050243_load_ext.sv
// Load result formatting: move the addressed bytes of the raw memory word down
// to bit 0, keep only the accessed size, then sign- or zero-extend.
module ysyx_22050243_load_ext
  import ysyx_22050243_mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [PMEM_W-1:0] raw,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);

  logic [PMEM_W-1:0] shifted;
  logic [PMEM_W-1:0] ext;

  // Shift by whole bytes, then extend from the top bit of the accessed size.
  always_comb begin
    shifted = raw >> {offset, 3'b000};
    ext     = shifted;
    case (size)
      SZ_B: ext = is_signed ? {{56{shifted[7]}}, shifted[7:0]}
                            : {56'h0, shifted[7:0]};
      SZ_H: ext = is_signed ? {{48{shifted[15]}}, shifted[15:0]}
                            : {48'h0, shifted[15:0]};
      SZ_W: ext = is_signed ? {{32{shifted[31]}}, shifted[31:0]}
                            : {32'h0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign data = ext[DATA_W-1:0];

endmodule

// File: rtl/ysyx_22050243_lsu_mem.sv
// LSU data-memory access unit: takes one load/store at a time, waits LATENCY
// cycles, performs a single physical-memory access, and returns an extended
// load result or store acknowledge. Misaligned or illegal-size requests are
// answered with resp_err and never touch memory.
// Optional build macro YSYX_22050243_MEM_TRACE_EN adds a cycle counter and a
// one-line log per memory access and per error response.
module ysyx_22050243_lsu_mem
  import ysyx_22050243_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  mem_state_e        state;
  mem_state_e        state_n;
  logic [3:0]        cnt;

  logic              wen_q;
  logic              signed_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [PMEM_W-1:0] raw_q;

  logic              req_fire;
  logic              req_bad;
  logic [PMEM_W-1:0] acc_addr;
  logic [PMEM_W-1:0] acc_wdata;
  logic [7:0]        acc_wmask;
  logic [DATA_W-1:0] load_data;

`ifdef YSYX_22050243_MEM_TRACE_EN
  logic [31:0]       trace_cycle;

  // Free-running cycle count stamped on each trace line.
  always_ff @(posedge clk) begin
    if (rst) trace_cycle <= '0;
    else     trace_cycle <= trace_cycle + 32'd1;
  end
`else
  // Tracing disabled: no cycle counter and no log output.
`endif

  assign req_fire = req_valid && (state == IDLE);
  assign req_bad  = ((req_addr[2:0] & size_align_mask(req_size)) != 3'b000)
                    || ((DATA_W == 32) && (req_size == SZ_D));

  assign acc_addr  = 64'({addr_q[ADDR_W-1:3], 3'b000});
  assign acc_wdata = 64'(wdata_q) << {addr_q[2:0], 3'b000};

  // Byte enables for the store; a 32-bit datapath never reaches past its lane.
  always_comb begin
    acc_wmask = 8'(size_byte_mask(size_q) << addr_q[2:0]);
    if (DATA_W == 32) acc_wmask = acc_wmask & (addr_q[2] ? 8'hF0 : 8'h0F);
  end

  // State register; reset abandons whatever transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: errors skip straight to the response, zero latency skips WAIT.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)           state_n = RESP;
          else if (LATENCY == 0) state_n = ACCESS;
          else                   state_n = WAIT;
        end
      end
      WAIT:    if (cnt <= 4'd1) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs; response data is forced to zero unless it is a load result.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = '0;
    if ((state == RESP) && !err_q && !wen_q) resp_rdata = load_data;
  end

  // Request capture, latency countdown and the single memory access per request.
  always_ff @(posedge clk) begin : datapath
    logic [PMEM_W-1:0] rd_word;
    if (rst) begin
      cnt      <= '0;
      wen_q    <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_B;
      raw_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            wen_q    <= req_wen;
            signed_q <= req_signed;
            err_q    <= req_bad;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            cnt      <= req_bad ? 4'd0 : 4'(LATENCY);
`ifdef YSYX_22050243_MEM_TRACE_EN
            if (req_bad)
              $display("[MEM] cyc=%0d ERR addr=%h size=%0d wmask=00 data=%h",
                       trace_cycle, req_addr, req_size, req_wdata);
`endif
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        ACCESS: begin
          if (wen_q) begin
            MEM_pmem_write(acc_addr, acc_wdata, acc_wmask, 1'b1);
`ifdef YSYX_22050243_MEM_TRACE_EN
            $display("[MEM] cyc=%0d W addr=%h size=%0d wmask=%h data=%h",
                     trace_cycle, acc_addr, size_q, acc_wmask, acc_wdata);
`endif
          end else begin
            MEM_pmem_read(acc_addr, rd_word, 1'b1);
            raw_q <= rd_word;
`ifdef YSYX_22050243_MEM_TRACE_EN
            $display("[MEM] cyc=%0d R addr=%h size=%0d wmask=00 data=%h",
                     trace_cycle, acc_addr, size_q, rd_word);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  ysyx_22050243_load_ext #(
    .DATA_W(DATA_W)
  ) u_load_ext (
    .raw      (raw_q),
    .offset   (addr_q[2:0]),
    .size     (size_q),
    .is_signed(signed_q),
    .data     (load_data)
  );

endmodule

// File: tb/tb_ysyx_22050243_lsu_mem.sv
// Bench for ysyx_22050243_lsu_mem: a LATENCY=2 instance driven from a table of
// load/store vectors plus stall and reset sequences, and a LATENCY=0 instance
// for back-to-back timing.
module tb_ysyx_22050243_lsu_mem;
  import ysyx_22050243_mem_pkg::*;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
  } vec_t;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_wen, req_signed;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_wen, z_req_signed;
  logic [63:0] z_req_addr, z_req_wdata;
  logic [1:0]  z_req_size;
  logic        z_resp_valid, z_resp_ready, z_resp_err;
  logic [63:0] z_resp_rdata;

  int total = 0;
  int bad   = 0;

  vec_t        vecs [NV];
  logic [63:0] got_rdata;
  logic        got_err;
  int          got_lat;
  int unsigned wr0, rd0;

  always #5 clk = ~clk;

  ysyx_22050243_lsu_mem #(.ADDR_W(64), .DATA_W(64), .LATENCY(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  ysyx_22050243_lsu_mem #(.ADDR_W(64), .DATA_W(64), .LATENCY(0)) u_dut_lat0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_wen   (z_req_wen),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_size  (z_req_size),
    .req_signed(z_req_signed),
    .resp_valid(z_resp_valid),
    .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata),
    .resp_err  (z_resp_err)
  );

  function automatic vec_t mk(input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [1:0] size,
                              input logic sgn, input logic [63:0] exp_rdata,
                              input logic exp_err, input int exp_lat,
                              input logic [7:0] exp_wmask,
                              input logic [63:0] exp_wdata);
    vec_t v;
    v.wen = wen;             v.addr = addr;           v.wdata = wdata;
    v.size = size;           v.sgn = sgn;             v.exp_rdata = exp_rdata;
    v.exp_err = exp_err;     v.exp_lat = exp_lat;     v.exp_wmask = exp_wmask;
    v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one request from a negedge with resp_ready high; returns the response
  // and the number of cycles from accept to resp_valid (bounded wait).
  task automatic apply_stimulus(input vec_t v, output logic [63:0] rdata,
                                output logic err, output int lat);
    req_valid  = 1'b1;
    req_wen    = v.wen;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_size   = v.size;
    req_signed = v.sgn;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc, accepts, r1_cyc, r2_cyc;
    logic fire;
    logic [63:0] r1_data, r2_data;

    vecs[0]  = mk(1, 64'h80000003, 64'hAB, SZ_B, 0, 64'h0, 0, 4, 8'h08, 64'h00000000AB000000);
    vecs[1]  = mk(1, 64'h80000000, 64'h80000000FFFFFF80, SZ_D, 0, 64'h0, 0, 4, 8'hFF, 64'h80000000FFFFFF80);
    vecs[2]  = mk(0, 64'h80000000, 64'h0, SZ_B, 1, 64'hFFFFFFFFFFFFFF80, 0, 4, 8'h00, 64'h0);
    vecs[3]  = mk(0, 64'h80000000, 64'h0, SZ_B, 0, 64'h0000000000000080, 0, 4, 8'h00, 64'h0);
    vecs[4]  = mk(0, 64'h80000002, 64'h0, SZ_W, 0, 64'h0, 1, 1, 8'h00, 64'h0);
    vecs[5]  = mk(0, 64'h80000002, 64'h0, SZ_H, 0, 64'h000000000000FFFF, 0, 4, 8'h00, 64'h0);
    vecs[6]  = mk(0, 64'h80000004, 64'h0, SZ_W, 1, 64'hFFFFFFFF80000000, 0, 4, 8'h00, 64'h0);
    vecs[7]  = mk(0, 64'h80000004, 64'h0, SZ_W, 0, 64'h0000000080000000, 0, 4, 8'h00, 64'h0);
    vecs[8]  = mk(1, 64'h80000006, 64'h1234, SZ_H, 0, 64'h0, 0, 4, 8'hC0, 64'h1234000000000000);
    vecs[9]  = mk(0, 64'h80000000, 64'h0, SZ_D, 0, 64'h12340000FFFFFF80, 0, 4, 8'h00, 64'h0);
    vecs[10] = mk(1, 64'h80000001, 64'h5555, SZ_H, 0, 64'h0, 1, 1, 8'h00, 64'h0);
    vecs[11] = mk(0, 64'h80000007, 64'h0, SZ_B, 1, 64'h0000000000000012, 0, 4, 8'h00, 64'h0);
    vecs[12] = mk(0, 64'h80000006, 64'h0, SZ_H, 1, 64'h0000000000001234, 0, 4, 8'h00, 64'h0);
    vecs[13] = mk(0, 64'h80000000, 64'h0, SZ_H, 1, 64'hFFFFFFFFFFFFFF80, 0, 4, 8'h00, 64'h0);

    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
    req_size = SZ_B; req_signed = 0; resp_ready = 1;
    z_req_valid = 0; z_req_wen = 0; z_req_addr = 0; z_req_wdata = 0;
    z_req_size = SZ_B; z_req_signed = 0; z_resp_ready = 1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_output("reset req_ready", 64'(req_ready), 64'd1);
    check_output("reset resp_valid", 64'(resp_valid), 64'd0);
    check_output("reset resp_rdata", resp_rdata, 64'd0);
    check_output("reset resp_err", 64'(resp_err), 64'd0);
    check_output("reset lat0 req_ready", 64'(z_req_ready), 64'd1);
    check_output("reset lat0 resp_valid", 64'(z_resp_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      wr0 = pmem_wr_cnt;
      rd0 = pmem_rd_cnt;
      apply_stimulus(vecs[i], got_rdata, got_err, got_lat);
      check_output($sformatf("v%0d rdata", i), got_rdata, vecs[i].exp_rdata);
      check_output($sformatf("v%0d err", i), 64'(got_err), 64'(vecs[i].exp_err));
      check_output($sformatf("v%0d latency", i), 64'(got_lat), 64'(vecs[i].exp_lat));
      check_output($sformatf("v%0d write calls", i), 64'(pmem_wr_cnt - wr0),
                   (vecs[i].wen && !vecs[i].exp_err) ? 64'd1 : 64'd0);
      check_output($sformatf("v%0d read calls", i), 64'(pmem_rd_cnt - rd0),
                   (!vecs[i].wen && !vecs[i].exp_err) ? 64'd1 : 64'd0);
      if (vecs[i].wen && !vecs[i].exp_err) begin
        check_output($sformatf("v%0d wmask", i), 64'(pmem_last_wmask), 64'(vecs[i].exp_wmask));
        check_output($sformatf("v%0d wdata", i), pmem_last_wdata, vecs[i].exp_wdata);
        check_output($sformatf("v%0d waddr", i), pmem_last_waddr,
                     {vecs[i].addr[63:3], 3'b000});
      end
    end

    // Response stall: resp_ready low for 5 cycles while another request waits.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000000;
    req_size = SZ_D; req_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_wen = 1'b1; req_addr = 64'h80000020; req_wdata = 64'h55; req_size = SZ_B;
    got_lat = 1;
    while (resp_valid !== 1'b1 && got_lat < 40) begin
      @(negedge clk);
      got_lat++;
    end
    check_output("stall latency", 64'(got_lat), 64'd4);
    wr0 = pmem_wr_cnt;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("stall%0d resp_valid", k), 64'(resp_valid), 64'd1);
      check_output($sformatf("stall%0d resp_rdata", k), resp_rdata, 64'h12340000FFFFFF80);
      check_output($sformatf("stall%0d req_ready", k), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check_output("after handshake req_ready", 64'(req_ready), 64'd1);
    check_output("after handshake resp_valid", 64'(resp_valid), 64'd0);
    check_output("held request ignored", 64'(pmem_wr_cnt - wr0), 64'd0);

    // Reset during WAIT of a store.
    wr0 = pmem_wr_cnt;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h80000010;
    req_wdata = 64'hDEADBEEFCAFEF00D; req_size = SZ_D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst wait req_ready", 64'(req_ready), 64'd1);
    check_output("rst wait resp_valid", 64'(resp_valid), 64'd0);
    check_output("rst wait resp_rdata", resp_rdata, 64'd0);
    check_output("rst wait resp_err", 64'(resp_err), 64'd0);
    repeat (6) @(negedge clk);
    check_output("rst wait no write", 64'(pmem_wr_cnt - wr0), 64'd0);
    check_output("rst wait mem", pmem_peek(64'h80000010), 64'd0);
    apply_stimulus(mk(0, 64'h80000000, 64'h0, SZ_D, 0, 64'h12340000FFFFFF80, 0, 4, 8'h00, 64'h0),
                   got_rdata, got_err, got_lat);
    check_output("post rst rdata", got_rdata, 64'h12340000FFFFFF80);
    check_output("post rst latency", 64'(got_lat), 64'd4);

    // Reset asserted across the ACCESS edge of a store.
    wr0 = pmem_wr_cnt;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h80000018;
    req_wdata = 64'h0123456789ABCDEF; req_size = SZ_D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst access no write", 64'(pmem_wr_cnt - wr0), 64'd0);
    check_output("rst access mem", pmem_peek(64'h80000018), 64'd0);
    check_output("rst access req_ready", 64'(req_ready), 64'd1);
    check_output("rst access resp_valid", 64'(resp_valid), 64'd0);

    // LATENCY=0: back-to-back double store then load, requester holding valid.
    z_req_valid = 1'b1; z_req_wen = 1'b1; z_req_addr = 64'h80000008;
    z_req_wdata = 64'h1122334455667788; z_req_size = SZ_D; z_req_signed = 1'b0;
    cyc = 0; accepts = 0; r1_cyc = -1; r2_cyc = -1; r1_data = '1; r2_data = '0;
    while (cyc < 12) begin
      fire = z_req_valid && z_req_ready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (fire) begin
        accepts++;
        if (accepts == 1) z_req_wen = 1'b0;
        else              z_req_valid = 1'b0;
      end
      if (z_resp_valid === 1'b1) begin
        if (r1_cyc < 0) begin
          r1_cyc  = cyc;
          r1_data = z_resp_rdata;
        end else if (r2_cyc < 0) begin
          r2_cyc  = cyc;
          r2_data = z_resp_rdata;
        end
      end
    end
    check_output("lat0 accepts", 64'(accepts), 64'd2);
    check_output("lat0 store resp cycle", 64'(r1_cyc), 64'd2);
    check_output("lat0 store rdata", r1_data, 64'd0);
    check_output("lat0 load resp cycle", 64'(r2_cyc), 64'd5);
    check_output("lat0 load rdata", r2_data, 64'h1122334455667788);
    check_output("lat0 mem", pmem_peek(64'h80000008), 64'h1122334455667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
